// File: rtl/top_system_pkg.sv
// rtl/top_system_pkg.sv - shared state encoding and op constants for the up/down counter
package top_system_pkg;

    typedef enum logic [1:0] {
        INIT = 2'b00,
        WAIT = 2'b01,
        UP   = 2'b10,
        DOWN = 2'b11
    } state_t;

    localparam logic OP_INC = 1'b1;
    localparam logic OP_DEC = 1'b0;

endpackage

// File: rtl/top_system_dp.sv
// rtl/top_system_dp.sv - counter register with increment/decrement and zero/max status
// Ports: clk, rst_n (async active-low), c_clr, c_ld, op (controls),
//        c (count), z (count is zero), m (count is all ones).
module top_system_dp
    import top_system_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c_clr,
    input  logic             c_ld,
    input  logic             op,
    output logic [WIDTH-1:0] c,
    output logic             z,
    output logic             m
);

    // Clear wins over load so INIT always leaves the register at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
        end else if (c_clr) begin
            c <= '0;
        end else if (c_ld) begin
            if (op == OP_INC) begin
                c <= c + WIDTH'(1);
            end else begin
                c <= c - WIDTH'(1);
            end
        end
    end

    assign z = (c == '0);
    assign m = (c == '1);

endmodule

// File: rtl/top_system_fsm.sv
// rtl/top_system_fsm.sv - control FSM turning u/d requests into clear/load/op controls
// Ports: clk, rst_n (async active-low), u, d (requests), z, m (datapath status),
//        c_clr, c_ld, op (datapath controls).
// TOP_SYSTEM_WRAP_EN: when defined, load is not gated by the z/m status flags.
module top_system_fsm
    import top_system_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic u,
    input  logic d,
    input  logic z,
    input  logic m,
    output logic c_clr,
    output logic c_ld,
    output logic op
);

    state_t current_state;

    // The request decode is identical from every non-INIT state, so UP<->DOWN
    // moves directly without passing through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= INIT;
        end else if (current_state == INIT) begin
            current_state <= WAIT;
        end else if (u && !d) begin
            current_state <= UP;
        end else if (d && !u) begin
            current_state <= DOWN;
        end else begin
            current_state <= WAIT;
        end
    end

    // Moore decode of the state; load is additionally gated by the status
    // flags so the register saturates instead of wrapping.
    always_comb begin
        c_clr = 1'b0;
        c_ld  = 1'b0;
        op    = OP_DEC;
        case (current_state)
            INIT: c_clr = 1'b1;
            UP: begin
                op = OP_INC;
`ifdef TOP_SYSTEM_WRAP_EN
                c_ld = 1'b1;
`else
                c_ld = ~m;
`endif
            end
            DOWN: begin
                op = OP_DEC;
`ifdef TOP_SYSTEM_WRAP_EN
                c_ld = 1'b1;
`else
                c_ld = ~z;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/top_system.sv
// rtl/top_system.sv - saturating up/down event counter top (FSM + datapath)
// Ports: clk, reset (async active-low), u (count up), d (count down), c_out (live count).
// TOP_SYSTEM_WRAP_EN: when defined, the count wraps at the ends instead of saturating.
module top_system
    import top_system_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             u,
    input  logic             d,
    output logic [WIDTH-1:0] c_out
);

    logic c_clr;
    logic c_ld;
    logic op;
    logic z;
    logic m;

    top_system_fsm fsm (
        .clk   (clk),
        .rst_n (reset),
        .u     (u),
        .d     (d),
        .z     (z),
        .m     (m),
        .c_clr (c_clr),
        .c_ld  (c_ld),
        .op    (op)
    );

    top_system_dp #(.WIDTH(WIDTH)) dp (
        .clk   (clk),
        .rst_n (reset),
        .c_clr (c_clr),
        .c_ld  (c_ld),
        .op    (op),
        .c     (c_out),
        .z     (z),
        .m     (m)
    );

endmodule

// File: tb/tb_top_system.sv
// tb/tb_top_system.sv - directed self-checking bench for top_system (WIDTH=4)
module tb_top_system;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         u;
    logic         d;
    logic [W-1:0] c_out;

    int total;
    int bad;

    top_system #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .u     (u),
        .d     (d),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        u     = 1'b0;
        d     = 1'b0;

        // reset held low for two cycles
        tick(2);
        check("rst_cout", 32'(c_out), 0);
        check("rst_state", 32'(dut.fsm.current_state), 0);
        check("rst_clr", 32'(dut.fsm.c_clr), 1);
        reset = 1'b1;
        #1;
        check("init_state", 32'(dut.fsm.current_state), 0);
        tick(1);
        check("wait_state", 32'(dut.fsm.current_state), 1);
        check("wait_z", 32'(dut.dp.z), 1);
        check("wait_m", 32'(dut.dp.m), 0);

        // count up: u for 5 edges then idle 2 edges -> 5
        u = 1'b1;
        tick(1);
        check("up_state", 32'(dut.fsm.current_state), 2);
        check("up_first", 32'(c_out), 0);
        tick(4);
        check("up_4", 32'(c_out), 4);
        u = 1'b0;
        tick(1);
        check("up_trail", 32'(c_out), 5);
        tick(1);
        check("up_done", 32'(c_out), 5);
        check("up_back_wait", 32'(dut.fsm.current_state), 1);

        // count down: d for 5 edges then idle -> 0
        d = 1'b1;
        tick(5);
        check("dn_5", 32'(c_out), 1);
        check("dn_state", 32'(dut.fsm.current_state), 3);
        d = 1'b0;
        tick(1);
        check("dn_trail", 32'(c_out), 0);
        check("dn_z", 32'(dut.dp.z), 1);
        tick(1);
        check("dn_hold", 32'(c_out), 0);

`ifndef TOP_SYSTEM_WRAP_EN
        // DOWN at zero: load is blocked
        d = 1'b1;
        tick(3);
        check("zero_hold", 32'(c_out), 0);
        check("zero_ld", 32'(dut.fsm.c_ld), 0);
        d = 1'b0;
        tick(2);
        check("zero_idle", 32'(c_out), 0);

        // saturate at max, then direct UP->DOWN and saturate at zero
        u = 1'b1;
        tick(20);
        check("sat_max", 32'(c_out), 15);
        check("sat_m", 32'(dut.dp.m), 1);
        check("sat_ld", 32'(dut.fsm.c_ld), 0);
        check("sat_state", 32'(dut.fsm.current_state), 2);
        u = 1'b0;
        d = 1'b1;
        tick(1);
        check("sat_to_dn", 32'(c_out), 15);
        check("sat_dn_state", 32'(dut.fsm.current_state), 3);
        tick(19);
        check("sat_zero", 32'(c_out), 0);
        check("sat_z", 32'(dut.dp.z), 1);
        check("sat_zero_ld", 32'(dut.fsm.c_ld), 0);
        d = 1'b0;
        tick(2);
        check("sat_idle", 32'(c_out), 0);
`endif

        // reach 7, then u=d=1 must not count
        u = 1'b1;
        tick(7);
        u = 1'b0;
        tick(1);
        check("seven", 32'(c_out), 7);
        u = 1'b1;
        d = 1'b1;
        tick(3);
        check("both_state", 32'(dut.fsm.current_state), 1);
        check("both_cout", 32'(c_out), 7);
        u = 1'b0;
        d = 1'b0;
        tick(1);

        // asynchronous reset mid-count
        u = 1'b1;
        tick(3);
        check("pre_arst", 32'(c_out), 9);
        #2;
        reset = 1'b0;
        #1;
        check("arst_cout", 32'(c_out), 0);
        check("arst_state", 32'(dut.fsm.current_state), 0);
        @(negedge clk);
        reset = 1'b1;
        u = 1'b0;
        tick(1);
        check("arst_wait", 32'(dut.fsm.current_state), 1);

`ifdef TOP_SYSTEM_WRAP_EN
        // wrap at both ends
        d = 1'b1;
        tick(2);
        check("wrap_dn", 32'(c_out), 15);
        d = 1'b0;
        tick(1);
        check("wrap_dn_trail", 32'(c_out), 14);
        u = 1'b1;
        tick(2);
        check("wrap_max", 32'(c_out), 15);
        tick(1);
        check("wrap_up", 32'(c_out), 0);
        u = 1'b0;
        tick(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
